// File: rtl/branch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_unit
// Purpose  : Computes the EX-stage branch/jump destination, writes it into the
//            downstream destination-address register (D + ClockEnable), then
//            holds a redirect request to fetch until it is accepted and
//            flushes the younger stages for a fixed number of Tick cycles.
// Revision : 1.0  initial release
// ============================================================================
module branch_redirect_unit #(
  parameter int NrOfBits    = 32,
  parameter int FlushCycles = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                ex_valid,
  input  logic [1:0]          ex_kind,
  input  logic                ex_taken,
  input  logic [NrOfBits-1:0] ex_pc,
  input  logic [15:0]         ex_imm,
  input  logic [25:0]         ex_jidx,
  input  logic [NrOfBits-1:0] ex_rs,
  input  logic                redir_ready,
  output logic [NrOfBits-1:0] bda_d,
  output logic                bda_we,
  output logic                redir_valid,
  output logic                flush,
  output logic                stall_ex,
  output logic [15:0]         redir_count
);

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PEND  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [1:0] K_BRANCH = 2'b01;
  localparam logic [1:0] K_J      = 2'b10;
  localparam logic [1:0] K_JR     = 2'b11;

  // Counter preload: flush stays up for FlushCycles Tick edges, the last one
  // being the edge on which the counter reads zero.
  localparam logic [3:0] FLUSH_LOAD = 4'(FlushCycles - 1);

  logic [1:0]          state_q, state_d;
  logic [NrOfBits-1:0] bda_addr_q, bda_addr_d;
  logic                bda_we_q, bda_we_d;
  logic                redir_valid_q, redir_valid_d;
  logic                flush_q, flush_d;
  logic [3:0]          flush_cnt_q, flush_cnt_d;
  logic [15:0]         redir_count_q, redir_count_d;

  logic [NrOfBits-1:0] pc4;
  logic [NrOfBits-1:0] br_target;
  logic [NrOfBits-1:0] j_target;
  logic [NrOfBits-1:0] jr_target;
  logic [NrOfBits-1:0] target;
  logic                need;

  // --------------------------------------------------------------------------
  // Destination address arithmetic (all modulo 2^NrOfBits)
  // --------------------------------------------------------------------------
  assign pc4       = ex_pc + NrOfBits'(4);
  assign br_target = pc4 + {{(NrOfBits-18){ex_imm[15]}}, ex_imm, 2'b00};
  assign jr_target = ex_rs & {{(NrOfBits-2){1'b1}}, 2'b00};

  // J keeps the region bits of pc4 above bit 27; none exist at 28 bits.
  generate
    if (NrOfBits > 28) begin : g_j_wide
      assign j_target = {pc4[NrOfBits-1:28], ex_jidx, 2'b00};
    end else begin : g_j_narrow
      assign j_target = {ex_jidx, 2'b00};
    end
  endgenerate

  // Select the destination for the current control-flow kind
  always_comb begin
    target = br_target;
    case (ex_kind)
      K_J:     target = j_target;
      K_JR:    target = jr_target;
      default: target = br_target;
    endcase
  end

  assign need = ex_valid &
                ((ex_kind == K_J) | (ex_kind == K_JR) |
                 ((ex_kind == K_BRANCH) & ex_taken));

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      bda_addr_q    <= '0;
      bda_we_q      <= 1'b0;
      redir_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      flush_cnt_q   <= 4'd0;
      redir_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      bda_addr_q    <= bda_addr_d;
      bda_we_q      <= bda_we_d;
      redir_valid_q <= redir_valid_d;
      flush_q       <= flush_d;
      flush_cnt_q   <= flush_cnt_d;
      redir_count_q <= redir_count_d;
    end
  end

  // Next-state: every transition is qualified by Tick
  always_comb begin
    state_d = state_q;
    if (Tick) begin
      case (state_q)
        S_IDLE:  if (need) state_d = S_PEND;
        S_PEND:  if (redir_ready) state_d = S_FLUSH;
        S_FLUSH: if (flush_cnt_q == 4'd0) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; everything holds while Tick=0
  always_comb begin
    bda_addr_d    = bda_addr_q;
    bda_we_d      = bda_we_q;
    redir_valid_d = redir_valid_q;
    flush_d       = flush_q;
    flush_cnt_d   = flush_cnt_q;
    redir_count_d = redir_count_q;
    if (Tick) begin
      case (state_q)
        S_IDLE: begin
          bda_we_d = 1'b0;
          if (need) begin
            bda_addr_d    = target;
            bda_we_d      = 1'b1;
            redir_valid_d = 1'b1;
          end
        end
        S_PEND: begin
          // Write enable lasts exactly one Tick edge; the register downstream
          // gates it with Tick too, so exactly one capture happens.
          bda_we_d = 1'b0;
          if (redir_ready) begin
            redir_valid_d = 1'b0;
            flush_d       = 1'b1;
            flush_cnt_d   = FLUSH_LOAD;
            if (redir_count_q != 16'hFFFF) begin
              redir_count_d = redir_count_q + 16'd1;
            end
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == 4'd0) begin
            flush_d = 1'b0;
          end else begin
            flush_cnt_d = flush_cnt_q - 4'd1;
          end
        end
        default: begin
          bda_we_d      = 1'b0;
          redir_valid_d = 1'b0;
          flush_d       = 1'b0;
          flush_cnt_d   = 4'd0;
        end
      endcase
    end
  end

  assign bda_d       = bda_addr_q;
  assign bda_we      = bda_we_q;
  assign redir_valid = redir_valid_q;
  assign flush       = flush_q;
  assign redir_count = redir_count_q;
  assign stall_ex    = (state_q == S_PEND);

endmodule
`default_nettype wire

// File: doc/branch_redirect_unit.md
# branch_redirect_unit

Computes the branch/jump destination address for the instruction resolving in EX and drives it into the downstream branch-destination-address register (D + ClockEnable). It then holds a redirect request to fetch until fetch accepts it and flushes the younger pipeline stages for a fixed number of cycles. The block sits between the EX-stage branch comparator and the branch destination address register / fetch PC mux.

## Interface
Parameters:
- NrOfBits, 32, address width; legal range NrOfBits >= 28.
- FlushCycles, 2, number of Tick-qualified cycles `flush` stays high after acceptance; legal range 1..15.

Ports:
- Clock  in  1  single system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Tick  in  1  global advance qualifier; when 0, all state holds.
- ex_valid  in  1  EX holds a valid control-flow instruction this cycle.
- ex_kind  in  2  00 none, 01 conditional branch, 10 J, 11 JR.
- ex_taken  in  1  condition result; used only when ex_kind=01.
- ex_pc  in  NrOfBits  PC of the EX instruction.
- ex_imm  in  16  branch offset in words, signed.
- ex_jidx  in  26  J-type index field.
- ex_rs  in  NrOfBits  register operand for JR.
- redir_ready  in  1  fetch accepts the redirect this cycle.
- bda_d  out  NrOfBits  destination address, to the register's D.
- bda_we  out  1  to the register's ClockEnable.
- redir_valid  out  1  redirect pending toward fetch.
- flush  out  1  squash IF/ID contents.
- stall_ex  out  1  hold EX and upstream stages.
- redir_count  out  16  count of accepted redirects, saturating.

## Operation
Target arithmetic, modulo 2^NrOfBits, with pc4 = ex_pc + 4:
- 01 taken: pc4 + (sign_extend(ex_imm) << 2).
- 10: {pc4[NrOfBits-1:28], ex_jidx, 2'b00}. When NrOfBits = 28, the upper field is empty.
- 11: ex_rs with bits [1:0] forced to 0.
- A redirect is needed when ex_valid & (ex_kind=10 | ex_kind=11 | (ex_kind=01 & ex_taken)).
- ex_kind=00, or 01 with ex_taken=0, causes no action.

FSM states (all transitions require Tick=1):
- IDLE: when a redirect is needed, load bda_d with the target, set bda_we=1 and redir_valid=1, and go to PEND.
- PEND: stall_ex=1 and redir_valid=1. bda_we clears at the first Tick edge in PEND. When redir_ready=1: clear redir_valid, set flush=1, load the flush counter with FlushCycles-1, increment redir_count (saturating at 0xFFFF), and go to FLUSH.
- FLUSH: flush=1 and stall_ex=0. The counter decrements each Tick. When the counter reads 0 on a Tick edge, clear flush and go to IDLE.

Other rules:
- ex_valid is ignored in PEND and FLUSH, because upstream is stalled or being squashed.
- bda_d holds its last value until the next IDLE capture.
- All outputs are registered, except that stall_ex = (state==PEND).

## Timing
- Reset, at any state, takes effect at the next edge: state IDLE; bda_d=0, bda_we=0, redir_valid=0, flush=0, stall_ex=0, redir_count=0. A pending redirect is abandoned.
- Latency: a request sampled at edge k gives bda_we=1, redir_valid=1, stall_ex=1 and valid bda_d during cycle k+1.
- bda_we is high for exactly one Tick-qualified edge. The downstream register gates it with Tick, so exactly one capture occurs.
- redir_ready may already be high in cycle k+1. Acceptance then happens at edge k+1, and flush is high for cycles k+2 .. k+1+FlushCycles.
- In the acceptance cycle, redir_valid and redir_ready are both high. redir_valid drops at the same edge where flush rises.
- While Tick=0, state, counters and outputs freeze; bda_we remains high until the next Tick edge.
- redir_count at 0xFFFF stays at 0xFFFF on further acceptances.

## Test plan
- Taken branch, with ex_pc=0x00400010, ex_imm=0xFFFC, redir_ready=1 -> bda_d=0x00400004 and bda_we pulses 1 cycle; flush is high for 2 cycles; redir_count=1.
- J with ex_pc=0x0FFFFFFC and ex_jidx=0x0000010 -> bda_d=0x10000040 (pc4 upper nibble 1); JR with ex_rs=0x1234567B -> bda_d=0x12345678.
- Not-taken branch (01, ex_taken=0), then ex_kind=00 -> no bda_we, redir_valid or flush, and redir_count unchanged.
- redir_ready held low for 5 cycles -> redir_valid and stall_ex stay high for 5 cycles while bda_we was high only in the first; a second ex_valid during PEND is ignored and bda_d is unchanged.
- Tick toggling 1,0,1 during PEND and FLUSH -> no state change on Tick=0 edges; flush spans exactly FlushCycles Tick edges.
- Reset asserted in PEND and again in FLUSH -> next cycle all outputs 0 and state IDLE; preloading redir_count to 0xFFFF and then accepting a redirect leaves it at 0xFFFF.
